// File: rtl/timer_array_pkg.sv
// Shared register map and CTRL layout for the timer_array block.
// The optional prescaler is enabled with the TIMER_ARRAY_PRESCALER_EN macro.
package timer_array_pkg;

    localparam logic [3:0] OFF_CTRL  = 4'h0;
    localparam logic [3:0] OFF_CMP   = 4'h4;
    localparam logic [3:0] OFF_COUNT = 4'h8;
    localparam logic [3:0] OFF_PRESC = 4'hC;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_PEND    = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int CTRL_IRQ_EN  = 3;

    // Member order matches the CTRL bit indices above (en is bit 0).
    typedef struct packed {
        logic irq_en;
        logic oneshot;
        logic pend;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        return {28'd0, c};
    endfunction

endpackage

// File: rtl/timer_array_ch.sv
// One timer channel: CTRL/CMP/PRESC registers, prescaler, counter and irq.
// Prescaler logic exists only when TIMER_ARRAY_PRESCALER_EN is defined.
module timer_array_ch
    import timer_array_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PSC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_we,
    input  logic             cmp_we,
    input  logic             presc_we,
    input  logic [31:0]      wdata,
    input  logic [31:0]      wmask,
    output ctrl_t            ctrl,
    output logic [CNT_W-1:0] cmp,
    output logic [CNT_W-1:0] count,
    output logic [PSC_W-1:0] presc,
    output logic             irq
);

    ctrl_t            ctrl_reg;
    ctrl_t            ctrl_next;
    logic [CNT_W-1:0] cmp_reg;
    logic [CNT_W-1:0] count_reg;
    logic             irq_reg;
    logic             tick;
    logic             match;

`ifdef TIMER_ARRAY_PRESCALER_EN
    logic [PSC_W-1:0] presc_reg;
    logic [PSC_W-1:0] psc_cnt_reg;
    logic             unused_psc;

    // >= keeps the divider sane if PRESC is lowered below the running count.
    assign tick       = ctrl_reg.en && (psc_cnt_reg >= presc_reg);
    assign presc      = presc_reg;
    assign unused_psc = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg   <= '0;
            psc_cnt_reg <= '0;
        end else begin
            if (presc_we)
                presc_reg <= (presc_reg & ~wmask[PSC_W-1:0]) |
                             (wdata[PSC_W-1:0] & wmask[PSC_W-1:0]);
            if (!ctrl_next.en || tick)
                psc_cnt_reg <= '0;
            else if (ctrl_reg.en)
                psc_cnt_reg <= psc_cnt_reg + 1'b1;
        end
    end
`else
    logic unused_psc;

    assign tick       = ctrl_reg.en;
    assign presc      = '0;
    assign unused_psc = &{1'b0, presc_we};
`endif

    logic unused_wr;
    assign unused_wr = &{1'b0, wdata, wmask, unused_psc};

    assign match = tick && (count_reg == cmp_reg);

    // Hardware match is applied after software so PEND set beats W1C.
    always_comb begin
        ctrl_next = ctrl_reg;
        if (ctrl_we) begin
            ctrl_next.en      = wdata[CTRL_EN];
            ctrl_next.oneshot = wdata[CTRL_ONESHOT];
            ctrl_next.irq_en  = wdata[CTRL_IRQ_EN];
            if (wdata[CTRL_PEND])
                ctrl_next.pend = 1'b0;
        end
        if (match) begin
            ctrl_next.pend = 1'b1;
            if (ctrl_reg.oneshot)
                ctrl_next.en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg  <= '0;
            cmp_reg   <= '0;
            count_reg <= '0;
            irq_reg   <= 1'b0;
        end else begin
            ctrl_reg <= ctrl_next;
            if (cmp_we)
                cmp_reg <= (cmp_reg & ~wmask[CNT_W-1:0]) |
                           (wdata[CNT_W-1:0] & wmask[CNT_W-1:0]);
            if (!ctrl_next.en || match)
                count_reg <= '0;
            else if (tick)
                count_reg <= count_reg + 1'b1;
            irq_reg <= ctrl_reg.pend & ctrl_reg.irq_en;
        end
    end

    assign ctrl  = ctrl_reg;
    assign cmp   = cmp_reg;
    assign count = count_reg;
    assign irq   = irq_reg;

endmodule

// File: rtl/timer_array.sv
// Array of NUM_CH timers behind a byte-addressed register bus.
// Optional per-channel prescaler: define TIMER_ARRAY_PRESCALER_EN.
module timer_array
    import timer_array_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PSC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    input  logic [3:0]        sel_i,
    input  logic              we_i,
    output logic [31:0]       data_o,
    output logic [NUM_CH-1:0] irq_o,
    output logic              irq_any_o
);

    logic [3:0]               ch_idx;
    logic [3:0]               reg_off;
    logic [31:0]              wmask;
    logic [NUM_CH-1:0]        ch_hit;
    logic [NUM_CH-1:0][31:0]  rd_word;
    logic                     unused_addr;

    assign ch_idx      = addr_i[7:4];
    assign reg_off     = addr_i[3:0];
    assign unused_addr = &{1'b0, addr_i[31:8]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wmask[gi*8 +: 8] = {8{sel_i[gi]}};
        end

        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            ctrl_t            ctrl;
            logic [CNT_W-1:0] cmp;
            logic [CNT_W-1:0] count;
            logic [PSC_W-1:0] presc;

            assign ch_hit[gi] = (ch_idx == 4'(gi));

            timer_array_ch #(
                .CNT_W (CNT_W),
                .PSC_W (PSC_W)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .ctrl_we  (we_i && ch_hit[gi] && sel_i[0] && (reg_off == OFF_CTRL)),
                .cmp_we   (we_i && ch_hit[gi] && (reg_off == OFF_CMP)),
                .presc_we (we_i && ch_hit[gi] && (reg_off == OFF_PRESC)),
                .wdata    (data_i),
                .wmask    (wmask),
                .ctrl     (ctrl),
                .cmp      (cmp),
                .count    (count),
                .presc    (presc),
                .irq      (irq_o[gi])
            );

            assign rd_word[gi] = (reg_off == OFF_CTRL)  ? ctrl_word(ctrl) :
                                 (reg_off == OFF_CMP)   ? 32'(cmp)        :
                                 (reg_off == OFF_COUNT) ? 32'(count)      :
                                 (reg_off == OFF_PRESC) ? 32'(presc)      : 32'd0;
        end
    endgenerate

    // Channel indices at or above NUM_CH hit nothing and read as zero.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch_hit[i])
                data_o = rd_word[i];
    end

    assign irq_any_o = |irq_o;

endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array: a default instance plus an 8-bit counter instance.
// Prescaler checks follow the TIMER_ARRAY_PRESCALER_EN build macro.
module tb_timer_array;
    import timer_array_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [3:0]  sel_i = '0;
    logic        we_i = 1'b0;
    logic        we8 = 1'b0;
    logic [31:0] data_o;
    logic [31:0] data8_o;
    logic [3:0]  irq_o;
    logic [0:0]  irq8_o;
    logic        irq_any_o;
    logic        irq8_any;
    logic [31:0] rv;
    int          n_checks = 0;
    int          n_fail = 0;

    always #50 clk = ~clk;

    timer_array dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .sel_i(sel_i),
        .we_i(we_i), .data_o(data_o), .irq_o(irq_o), .irq_any_o(irq_any_o)
    );

    timer_array #(.NUM_CH(1), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .sel_i(sel_i),
        .we_i(we8), .data_o(data8_o), .irq_o(irq8_o), .irq_any_o(irq8_any)
    );

    task automatic wr(input bit t8, input int ch, input logic [3:0] off,
                      input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        addr_i = {24'd0, 4'(ch), off};
        data_i = d;
        sel_i  = s;
        if (t8) we8 = 1'b1; else we_i = 1'b1;
        @(posedge clk);
        #1;
        we_i = 1'b0;
        we8  = 1'b0;
        $display("write %s ch%0d off %h data %h sel %h", t8 ? "dut8" : "dut", ch, off, d, s);
    endtask

    task automatic rd(input bit t8, input int ch, input logic [3:0] off, output logic [31:0] v);
        addr_i = {24'd0, 4'(ch), off};
        #1;
        v = t8 ? data8_o : data_o;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 4; c++) begin
            for (int o = 0; o < 4; o++) begin
                rd(0, c, 4'(o * 4), rv);
                n_checks++; if (rv !== 32'd0) begin n_fail++; $display("FAIL reset_reg ch%0d off%0d: got %h expected 0", c, o * 4, rv); end
            end
        end
        n_checks++; if (irq_o !== 4'd0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0000", irq_o); end
        n_checks++; if (irq_any_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq_any: got %b expected 0", irq_any_o); end
    endtask

    task automatic test_regs;
        wr(0, 3, OFF_CMP, 32'hAABBCCDD, 4'h5);
        rd(0, 3, OFF_CMP, rv);
        n_checks++; if (rv !== 32'h00BB00DD) begin n_fail++; $display("FAIL cmp_lanes_a: got %h expected 00bb00dd", rv); end
        wr(0, 3, OFF_CMP, 32'h11223344, 4'hA);
        rd(0, 3, OFF_CMP, rv);
        n_checks++; if (rv !== 32'h11BB33DD) begin n_fail++; $display("FAIL cmp_lanes_b: got %h expected 11bb33dd", rv); end
        wr(0, 3, OFF_CTRL, 32'h9, 4'hE);
        rd(0, 3, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'h0) begin n_fail++; $display("FAIL ctrl_no_sel0: got %h expected 0", rv); end
        wr(0, 3, OFF_CTRL, 32'hFFFFFFF4, 4'hF);
        rd(0, 3, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'h4) begin n_fail++; $display("FAIL ctrl_upper_bits: got %h expected 4", rv); end
        wr(0, 3, OFF_CTRL, 32'h0, 4'h1);
        rd(0, 3, 4'h1, rv);
        n_checks++; if (rv !== 32'h0) begin n_fail++; $display("FAIL unmapped_off: got %h expected 0", rv); end
        wr(0, 3, OFF_COUNT, 32'h77, 4'hF);
        rd(0, 3, OFF_COUNT, rv);
        n_checks++; if (rv !== 32'h0) begin n_fail++; $display("FAIL count_ro: got %h expected 0", rv); end
`ifdef TIMER_ARRAY_PRESCALER_EN
        wr(0, 3, OFF_PRESC, 32'h00012345, 4'hF);
        rd(0, 3, OFF_PRESC, rv);
        n_checks++; if (rv !== 32'h2345) begin n_fail++; $display("FAIL presc_width: got %h expected 2345", rv); end
        wr(0, 3, OFF_PRESC, 32'h0000FFFF, 4'h2);
        rd(0, 3, OFF_PRESC, rv);
        n_checks++; if (rv !== 32'hFF45) begin n_fail++; $display("FAIL presc_lane: got %h expected ff45", rv); end
        wr(0, 3, OFF_PRESC, 32'h0, 4'hF);
`else
        wr(0, 3, OFF_PRESC, 32'h7, 4'hF);
        rd(0, 3, OFF_PRESC, rv);
        n_checks++; if (rv !== 32'h0) begin n_fail++; $display("FAIL presc_absent: got %h expected 0", rv); end
`endif
    endtask

    task automatic test_periodic;
        wr(0, 0, OFF_CMP, 32'd5, 4'hF);
        wr(0, 0, OFF_CTRL, 32'h9, 4'h1);
        wait_cyc(5);
        rd(0, 0, OFF_COUNT, rv);
        n_checks++; if (rv !== 32'd5) begin n_fail++; $display("FAIL per_count5: got %h expected 5", rv); end
        rd(0, 0, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'h9) begin n_fail++; $display("FAIL per_ctrl_pre: got %h expected 9", rv); end
        wait_cyc(1);
        rd(0, 0, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'hB) begin n_fail++; $display("FAIL per_pend: got %h expected b", rv); end
        rd(0, 0, OFF_COUNT, rv);
        n_checks++; if (rv !== 32'd0) begin n_fail++; $display("FAIL per_count0: got %h expected 0", rv); end
        n_checks++; if (irq_o[0] !== 1'b0) begin n_fail++; $display("FAIL per_irq_delay: got %b expected 0", irq_o[0]); end
        wait_cyc(1);
        n_checks++; if (irq_o[0] !== 1'b1) begin n_fail++; $display("FAIL per_irq: got %b expected 1", irq_o[0]); end
        n_checks++; if (irq_any_o !== 1'b1) begin n_fail++; $display("FAIL per_irq_any: got %b expected 1", irq_any_o); end
        wr(0, 0, OFF_CTRL, 32'hB, 4'h1);
        rd(0, 0, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'h9) begin n_fail++; $display("FAIL per_w1c: got %h expected 9", rv); end
        wait_cyc(1);
        n_checks++; if (irq_o[0] !== 1'b0) begin n_fail++; $display("FAIL per_irq_clr: got %b expected 0", irq_o[0]); end
        wait_cyc(2);
        rd(0, 0, OFF_COUNT, rv);
        n_checks++; if (rv !== 32'd5) begin n_fail++; $display("FAIL per2_count5: got %h expected 5", rv); end
        wait_cyc(1);
        rd(0, 0, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'hB) begin n_fail++; $display("FAIL per2_pend: got %h expected b", rv); end
    endtask

`ifdef TIMER_ARRAY_PRESCALER_EN
    task automatic test_oneshot;
        wr(0, 1, OFF_PRESC, 32'd3, 4'hF);
        wr(0, 1, OFF_CMP, 32'd2, 4'hF);
        wr(0, 1, OFF_CTRL, 32'hD, 4'h1);
        wait_cyc(11);
        rd(0, 1, OFF_COUNT, rv);
        n_checks++; if (rv !== 32'd2) begin n_fail++; $display("FAIL os_count2: got %h expected 2", rv); end
        rd(0, 1, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'hD) begin n_fail++; $display("FAIL os_ctrl_pre: got %h expected d", rv); end
        wait_cyc(1);
        rd(0, 1, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'hE) begin n_fail++; $display("FAIL os_match: got %h expected e", rv); end
        rd(0, 1, OFF_COUNT, rv);
        n_checks++; if (rv !== 32'd0) begin n_fail++; $display("FAIL os_count0: got %h expected 0", rv); end
        wait_cyc(1);
        n_checks++; if (irq_o[1] !== 1'b1) begin n_fail++; $display("FAIL os_irq: got %b expected 1", irq_o[1]); end
        wr(0, 1, OFF_CTRL, 32'hE, 4'h1);
        wait_cyc(20);
        rd(0, 1, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'hC) begin n_fail++; $display("FAIL os_no_repeat: got %h expected c", rv); end
        rd(0, 1, OFF_COUNT, rv);
        n_checks++; if (rv !== 32'd0) begin n_fail++; $display("FAIL os_count_hold: got %h expected 0", rv); end
        n_checks++; if (irq_o[1] !== 1'b0) begin n_fail++; $display("FAIL os_irq_clr: got %b expected 0", irq_o[1]); end
    endtask
`else
    task automatic test_no_prescaler;
        wr(0, 1, OFF_PRESC, 32'd7, 4'hF);
        rd(0, 1, OFF_PRESC, rv);
        n_checks++; if (rv !== 32'd0) begin n_fail++; $display("FAIL np_presc: got %h expected 0", rv); end
        wr(0, 1, OFF_CMP, 32'd3, 4'hF);
        wr(0, 1, OFF_CTRL, 32'h1, 4'h1);
        wait_cyc(3);
        rd(0, 1, OFF_COUNT, rv);
        n_checks++; if (rv !== 32'd3) begin n_fail++; $display("FAIL np_count3: got %h expected 3", rv); end
        rd(0, 1, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'h1) begin n_fail++; $display("FAIL np_ctrl_pre: got %h expected 1", rv); end
        wait_cyc(1);
        rd(0, 1, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'h3) begin n_fail++; $display("FAIL np_match1: got %h expected 3", rv); end
        wr(0, 1, OFF_CTRL, 32'h3, 4'h1);
        wait_cyc(2);
        rd(0, 1, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'h1) begin n_fail++; $display("FAIL np_ctrl_mid: got %h expected 1", rv); end
        wait_cyc(1);
        rd(0, 1, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'h3) begin n_fail++; $display("FAIL np_match2: got %h expected 3", rv); end
        wr(0, 1, OFF_CTRL, 32'h2, 4'h1);
        rd(0, 1, OFF_COUNT, rv);
        n_checks++; if (rv !== 32'd0) begin n_fail++; $display("FAIL np_disable: got %h expected 0", rv); end
    endtask
`endif

    task automatic test_w1c_race;
        wr(0, 2, OFF_CMP, 32'd2, 4'hF);
        wr(0, 2, OFF_CTRL, 32'h9, 4'h1);
        wait_cyc(2);
        rd(0, 2, OFF_COUNT, rv);
        n_checks++; if (rv !== 32'd2) begin n_fail++; $display("FAIL race_count2: got %h expected 2", rv); end
        wr(0, 2, OFF_CTRL, 32'hB, 4'h1);
        rd(0, 2, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'hB) begin n_fail++; $display("FAIL race_pend_wins: got %h expected b", rv); end
        wait_cyc(1);
        n_checks++; if (irq_o[2] !== 1'b1) begin n_fail++; $display("FAIL race_irq: got %b expected 1", irq_o[2]); end
        wr(0, 2, OFF_CTRL, 32'h2, 4'h1);
        rd(0, 2, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'h0) begin n_fail++; $display("FAIL race_stop_ctrl: got %h expected 0", rv); end
        rd(0, 2, OFF_COUNT, rv);
        n_checks++; if (rv !== 32'd0) begin n_fail++; $display("FAIL race_stop_count: got %h expected 0", rv); end
        wait_cyc(1);
        n_checks++; if (irq_o[2] !== 1'b0) begin n_fail++; $display("FAIL race_irq_clr: got %b expected 0", irq_o[2]); end
    endtask

    task automatic test_wrap;
        wr(1, 0, OFF_CMP, 32'h123456FF, 4'hF);
        rd(1, 0, OFF_CMP, rv);
        n_checks++; if (rv !== 32'hFF) begin n_fail++; $display("FAIL wrap_cmp_width: got %h expected ff", rv); end
        wr(1, 0, OFF_CTRL, 32'h9, 4'h1);
        wait_cyc(31);
        wr(1, 0, OFF_CMP, 32'h10, 4'hF);
        rd(1, 0, OFF_COUNT, rv);
        n_checks++; if (rv !== 32'h20) begin n_fail++; $display("FAIL wrap_count20: got %h expected 20", rv); end
        wait_cyc(223);
        rd(1, 0, OFF_COUNT, rv);
        n_checks++; if (rv !== 32'hFF) begin n_fail++; $display("FAIL wrap_countff: got %h expected ff", rv); end
        wait_cyc(1);
        rd(1, 0, OFF_COUNT, rv);
        n_checks++; if (rv !== 32'h00) begin n_fail++; $display("FAIL wrap_count00: got %h expected 0", rv); end
        rd(1, 0, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'h9) begin n_fail++; $display("FAIL wrap_no_pend: got %h expected 9", rv); end
        wait_cyc(16);
        rd(1, 0, OFF_COUNT, rv);
        n_checks++; if (rv !== 32'h10) begin n_fail++; $display("FAIL wrap_count10: got %h expected 10", rv); end
        wait_cyc(1);
        rd(1, 0, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'hB) begin n_fail++; $display("FAIL wrap_match: got %h expected b", rv); end
        wait_cyc(1);
        n_checks++; if (irq8_o[0] !== 1'b1) begin n_fail++; $display("FAIL wrap_irq: got %b expected 1", irq8_o[0]); end
    endtask

    task automatic test_reset_midop;
        wr(0, 3, OFF_CMP, 32'd1, 4'hF);
        wr(0, 3, OFF_CTRL, 32'h9, 4'h1);
        wait_cyc(3);
        n_checks++; if (irq_o[3] !== 1'b1) begin n_fail++; $display("FAIL mid_irq3: got %b expected 1", irq_o[3]); end
        @(negedge clk);
        rst    = 1'b1;
        addr_i = {24'd0, 4'd0, OFF_CMP};
        data_i = 32'h55;
        sel_i  = 4'hF;
        we_i   = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        we_i = 1'b0;
        $display("reset pulse with coincident write ch0 cmp 00000055");
        test_reset;
        rd(1, 0, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'h0) begin n_fail++; $display("FAIL mid_dut8_ctrl: got %h expected 0", rv); end
        n_checks++; if (irq8_any !== 1'b0) begin n_fail++; $display("FAIL mid_dut8_irq: got %b expected 0", irq8_any); end
        wr(0, 5, OFF_CMP, 32'hAB, 4'hF);
        wr(0, 5, OFF_CTRL, 32'h9, 4'h1);
        rd(0, 5, OFF_CMP, rv);
        n_checks++; if (rv !== 32'h0) begin n_fail++; $display("FAIL ch5_cmp: got %h expected 0", rv); end
        rd(0, 1, OFF_CMP, rv);
        n_checks++; if (rv !== 32'h0) begin n_fail++; $display("FAIL ch5_alias_cmp: got %h expected 0", rv); end
        rd(0, 1, OFF_CTRL, rv);
        n_checks++; if (rv !== 32'h0) begin n_fail++; $display("FAIL ch5_alias_ctrl: got %h expected 0", rv); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset;
        test_regs;
        test_periodic;
`ifdef TIMER_ARRAY_PRESCALER_EN
        test_oneshot;
`else
        test_no_prescaler;
`endif
        test_w1c_race;
        test_wrap;
        test_reset_midop;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_array.md
TIMER_ARRAY -- requirements
Module: timer_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent timer channels (1..15).
REQ-002 SHALL have parameter CNT_W, default 32, counter/compare width (8..32).
REQ-003 SHALL have parameter PSC_W, default 16, prescaler width (1..16).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port addr_i  input  32  byte address; addr_i[7:4] = channel index, addr_i[3:0] = register offset.
REQ-007 SHALL have port data_i  input  32  write data.
REQ-008 SHALL have port sel_i  input  4  byte-lane write enables.
REQ-009 SHALL have port we_i  input  1  write strobe.
REQ-010 SHALL have port data_o  output  32  read data, combinational from addr_i.
REQ-011 SHALL have port irq_o  output  NUM_CH  per-channel interrupt, registered.
REQ-012 SHALL have port irq_any_o  output  1  OR of irq_o.

Function
REQ-013 SHALL provide per channel: CTRL 0x0, CMP 0x4, COUNT 0x8 (read-only), PRESC 0xC; channel index >= NUM_CH or unmapped offset reads 0, writes ignored.
REQ-014 CTRL bits SHALL be: [0] EN, [1] PEND (W1C), [2] ONESHOT, [3] IRQ_EN; other bits read 0.
REQ-015 CTRL [0],[2],[3] and PEND-clear SHALL take effect only when sel_i[0]; CMP/PRESC SHALL honour each byte lane; bits above CNT_W/PSC_W read 0.
REQ-016 Writes SHALL update registers at the next posedge; data_o SHALL reflect current register state.
REQ-017 With EN=1, prescaler SHALL count 0..PRESC and emit one tick per PRESC+1 clocks; PRESC=0 ticks every clock.
REQ-018 On tick, COUNT SHALL increment modulo 2^CNT_W unless COUNT==CMP.
REQ-019 On tick with COUNT==CMP: PEND SHALL set, COUNT SHALL return to 0; if ONESHOT=1, EN SHALL clear in the same cycle.
REQ-020 With EN=0, COUNT and prescaler SHALL hold 0; clearing EN mid-count SHALL zero both next cycle.
REQ-021 Hardware PEND set SHALL win over simultaneous software W1C.
REQ-022 irq_o[i] SHALL be registered PEND & IRQ_EN, one cycle after PEND is set; it SHALL stay high until PEND cleared or IRQ_EN cleared.
REQ-023 CMP=0 SHALL produce a match every tick (period = PRESC+1 clocks).
REQ-024 Writing CMP below current COUNT SHALL let COUNT wrap at 2^CNT_W before matching.

Reset
REQ-025 While rst=1 at posedge, all CTRL, CMP, COUNT, PRESC, prescaler state and irq_o SHALL be 0; irq_any_o 0.
REQ-026 Reset mid-operation SHALL abort counting; a write coincident with rst SHALL be discarded.

Configuration
REQ-027 Macro TIMER_ARRAY_PRESCALER_EN: defined -> prescaler per REQ-017; undefined -> no prescaler logic, tick every clock, PRESC reads 0, writes ignored.

Structure
REQ-028 Package timer_array_pkg SHALL hold register offsets, CTRL bit indices and the ctrl bitfield typedef.
REQ-029 Per-channel logic SHALL live in sub-module timer_array_ch, instantiated NUM_CH times by generate; top holds address decode, read mux, irq OR.

Verification
REQ-030 Ch0 PRESC=0, CMP=5, CTRL=0x9 -> PEND set and irq_o[0]=1 one cycle later, period 6 clocks, COUNT back to 0.
REQ-031 Ch1 PRESC=3, CMP=2, ONESHOT, CTRL=0xD -> single match after 12 clocks, EN reads 0, COUNT stays 0, no further PEND after W1C.
REQ-032 Ch2 periodic: W1C PEND (write 0x2|0x9) on exact match cycle -> PEND remains 1.
REQ-033 CNT_W=8, CMP=0x10, COUNT at 0x20 -> COUNT wraps 0xFF->0x00, matches at 0x10.
REQ-034 Assert rst while ch0 and ch3 running -> all registers, irq_o, irq_any_o read 0 next cycle; write to ch index 5 (NUM_CH=4) -> reads 0.
REQ-035 Build without TIMER_ARRAY_PRESCALER_EN, write PRESC=7 -> reads 0, CMP=3 matches every 4 clocks.
